// File: rtl/strait_seq_pkg.sv
// strait_seq_pkg: state encoding, status bit indices and helpers shared by the STRAIT self-test sequencer
package strait_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_M_SETUP = 4'd1,
    S_M_START = 4'd2,
    S_M_WAIT  = 4'd3,
    S_L_SETUP = 4'd4,
    S_L_START = 4'd5,
    S_L_WAIT  = 4'd6,
    S_R_WAIT  = 4'd7,
    S_DONE    = 4'd8
  } seq_state_t;
  localparam int STATUS_W   = 5;
  localparam int ST_MBIST   = 0;
  localparam int ST_TD      = 1;
  localparam int ST_REC     = 2;
  localparam int ST_TIMEOUT = 3;
  localparam int ST_ABORT   = 4;
  function automatic logic is_wait(seq_state_t s);
    return s inside {S_M_WAIT, S_L_WAIT, S_R_WAIT};
  endfunction
endpackage

// File: rtl/strait_seq_watchdog.sv
// strait_seq_watchdog: per-phase wait counter that flags when LIMIT cycles have been spent waiting
module strait_seq_watchdog #(
  parameter int LIMIT = 65535,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [W-1:0] cnt_q;
  assign expired = enable && cnt_q == W'(LIMIT - 1);
  // count cycles spent in the current wait phase, restarting on each phase entry
  always_ff @(posedge clk)
    if (rst || clear) cnt_q <= '0;
    else if (enable && !expired) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/strait_test_sequencer.sv
// strait_test_sequencer: MBIST -> LBIST -> BISR power-on self-test flow controller for STRAIT (watchdog via STRAIT_SEQ_TIMEOUT_EN)
module strait_test_sequencer
  import strait_seq_pkg::*;
#(
  parameter int LBIST_DONE_PULSES = 2,
  parameter int TIMEOUT_CYCLES    = 65535,
  parameter int TO_W              = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                abort,
  output logic                strait_start,
  output logic                strait_test_mode,
  output logic                strait_bist_mode,
  input  logic                strait_test_done,
  input  logic                strait_mbist_fail,
  input  logic                strait_td_error_flag,
  input  logic                strait_recovery_done,
  input  logic                strait_recovery_succ,
  output logic                busy,
  output logic                done,
  output logic [STATUS_W-1:0] status,
  output logic                array_ready,
  output logic [2:0]          phase
);
  localparam int CNT_W = $clog2(LBIST_DONE_PULSES + 1);
  seq_state_t          state_q, state_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rec_seen_q, rec_seen_d, rec_succ_q, rec_succ_d, done_q;
  logic                busy_w, wd_expired, rec_ok;
  assign busy_w = state_q != S_IDLE && state_q != S_DONE;
  assign rec_ok = strait_recovery_done ? strait_recovery_succ : rec_succ_q;
`ifdef STRAIT_SEQ_TIMEOUT_EN
  strait_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES), .W(TO_W)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (is_wait(state_d) && state_d != state_q),
    .enable  (is_wait(state_q)),
    .expired (wd_expired)
  );
`else
  logic unused_to;
  assign unused_to  = ^{TIMEOUT_CYCLES, TO_W};
  assign wd_expired = 1'b0;
`endif
  // next-state, status accumulation and recovery latch; abort outranks everything in a busy state
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    rec_seen_d = rec_seen_q;
    rec_succ_d = rec_succ_q;
    if (state_q inside {S_L_START, S_L_WAIT, S_R_WAIT} && strait_recovery_done) begin
      rec_seen_d = 1'b1;
      rec_succ_d = strait_recovery_succ;
    end
    if (busy_w && abort) begin
      state_d            = S_DONE;
      status_d[ST_ABORT] = 1'b1;
    end else if (!busy_w) begin
      if (go) begin
        state_d    = S_M_SETUP;
        status_d   = '0;
        cnt_d      = '0;
        rec_seen_d = 1'b0;
        rec_succ_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_M_SETUP: state_d = S_M_START;
        S_M_START: state_d = S_M_WAIT;
        S_M_WAIT:
          if (strait_test_done) begin
            status_d[ST_MBIST] = strait_mbist_fail;
            state_d            = strait_mbist_fail ? S_DONE : S_L_SETUP;
          end
        S_L_SETUP: state_d = S_L_START;
        S_L_START: state_d = S_L_WAIT;
        S_L_WAIT:
          if (strait_test_done) begin
            if (cnt_q == CNT_W'(LBIST_DONE_PULSES - 1)) begin
              status_d[ST_TD] = strait_td_error_flag;
              state_d         = S_R_WAIT;
            end else cnt_d = cnt_q + 1'b1;
          end
        S_R_WAIT:
          if (strait_recovery_done || rec_seen_q) begin
            status_d[ST_REC] = ~rec_ok;
            state_d          = S_DONE;
          end
        default: state_d = S_IDLE;
      endcase
      if (wd_expired && state_d == state_q) begin
        status_d[ST_TIMEOUT] = 1'b1;
        state_d              = S_DONE;
      end
    end
  end
  // state and status registers; done flags the first cycle spent in DONE
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= S_IDLE;
      status_q   <= '0;
      cnt_q      <= '0;
      rec_seen_q <= 1'b0;
      rec_succ_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cnt_q      <= cnt_d;
      rec_seen_q <= rec_seen_d;
      rec_succ_q <= rec_succ_d;
      done_q     <= state_d == S_DONE && state_q != S_DONE;
    end
  assign strait_start     = state_q == S_M_START || state_q == S_L_START;
  assign strait_test_mode = busy_w;
  assign strait_bist_mode = state_q inside {S_L_SETUP, S_L_START, S_L_WAIT, S_R_WAIT};
  assign busy             = busy_w;
  assign done             = done_q;
  assign status           = status_q;
  assign array_ready      = state_q == S_DONE && status_q == '0;
  assign phase            = state_q[2:0];
endmodule

// File: tb/tb_strait_test_sequencer.sv
// tb_strait_test_sequencer: table-driven and randomized self-test flows against a scenario-level status model
module tb_strait_test_sequencer;
  logic clk = 0, rst = 1, go = 0, abort = 0;
  logic strait_test_done = 0, strait_mbist_fail = 0, strait_td_error_flag = 0;
  logic strait_recovery_done = 0, strait_recovery_succ = 0;
  logic strait_start, strait_test_mode, strait_bist_mode, busy, done, array_ready;
  logic [4:0] status;
  logic [2:0] phase;
  int n_chk = 0, n_fail = 0;
  int starts = 0, dones = 0;
  bit bm_seen = 0, mon_clr = 0;
  typedef struct {
    bit mf, td, succ, early, ab, inj;
    logic [4:0] st;
    bit rdy;
    int nstart;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  strait_test_sequencer #(.LBIST_DONE_PULSES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .strait_start(strait_start), .strait_test_mode(strait_test_mode), .strait_bist_mode(strait_bist_mode),
    .strait_test_done(strait_test_done), .strait_mbist_fail(strait_mbist_fail),
    .strait_td_error_flag(strait_td_error_flag), .strait_recovery_done(strait_recovery_done),
    .strait_recovery_succ(strait_recovery_succ), .busy(busy), .done(done), .status(status),
    .array_ready(array_ready), .phase(phase)
  );

  always @(negedge clk)
    if (mon_clr) begin
      starts <= 0; dones <= 0; bm_seen <= 0;
    end else begin
      starts  <= starts + int'(strait_start);
      dones   <= dones + int'(done);
      bm_seen <= bm_seen | strait_bist_mode;
    end

  function automatic logic [4:0] model(bit mf, bit td, bit succ, bit ab);
    if (ab) return 5'b10000;
    if (mf) return 5'b00001;
    return {2'b00, !succ, td, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic clear_mon;
    mon_clr = 1; step; step; mon_clr = 0;
  endtask

  task automatic pulse_go;
    go = 1; step; go = 0;
  endtask

  task automatic pulse_td(input bit mf, input bit td, input int gap);
    repeat (gap) step;
    strait_test_done = 1; strait_mbist_fail = mf; strait_td_error_flag = td;
    step;
    strait_test_done = 0; strait_mbist_fail = 0; strait_td_error_flag = 0;
  endtask

  task automatic pulse_rec(input bit succ, input int gap);
    repeat (gap) step;
    strait_recovery_done = 1; strait_recovery_succ = succ;
    step;
    strait_recovery_done = 0; strait_recovery_succ = 0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!strait_start && n < 30);
    check({name, " start"}, 32'(strait_start), 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 60);
    check({name, " done"}, 32'(done), 1);
  endtask

  task automatic run_flow(input string name, input vec_t v);
    clear_mon;
    pulse_go;
    @(negedge clk);
    check({name, " go"}, {busy, strait_test_mode, strait_bist_mode, status}, {3'b110, 5'b0});
    wait_start(name);
    if (v.inj) begin
      strait_test_done = 1; strait_mbist_fail = 1;
      step;
      strait_test_done = 0; strait_mbist_fail = 0; go = 1;
      step;
      go = 0;
      pulse_td(v.mf, 0, 0);
    end else begin
      step;
      pulse_td(v.mf, 0, $urandom_range(0, 3));
    end
    if (!v.mf) begin
      wait_start(name);
      step;
      pulse_td(0, 0, $urandom_range(0, 3));
      if (v.ab) begin
        abort = 1; go = 1; step; abort = 0; go = 0;
      end else begin
        if (v.early) pulse_rec(v.succ, $urandom_range(0, 2));
        pulse_td(0, v.td, $urandom_range(0, 3));
        if (!v.early) pulse_rec(v.succ, $urandom_range(0, 3));
      end
    end
    wait_done(name);
    check({name, " status"}, 32'(status), 32'(v.st));
    check({name, " ready/mode/busy"}, {array_ready, strait_test_mode, strait_bist_mode, busy}, {v.rdy, 3'b000});
    @(negedge clk);
    check({name, " done width"}, 32'(done), 0);
    check({name, " starts"}, starts, v.nstart);
    check({name, " dones"}, dones, 1);
    check({name, " bist_mode seen"}, 32'(bm_seen), 32'(!v.mf));
    check({name, " hold"}, {array_ready, status}, {v.rdy, v.st});
  endtask

  initial begin
    vec_t r;
    tbl[0] = '{mf:0, td:0, succ:1, early:0, ab:0, inj:1, st:5'b00000, rdy:1, nstart:2};
    tbl[1] = '{mf:1, td:0, succ:1, early:0, ab:0, inj:0, st:5'b00001, rdy:0, nstart:1};
    tbl[2] = '{mf:0, td:1, succ:1, early:0, ab:0, inj:0, st:5'b00010, rdy:0, nstart:2};
    tbl[3] = '{mf:0, td:0, succ:0, early:1, ab:0, inj:0, st:5'b00100, rdy:0, nstart:2};
    tbl[4] = '{mf:0, td:0, succ:1, early:0, ab:1, inj:0, st:5'b10000, rdy:0, nstart:2};
    tbl[5] = '{mf:0, td:0, succ:1, early:1, ab:0, inj:0, st:5'b00000, rdy:1, nstart:2};
    tbl[6] = '{mf:0, td:1, succ:0, early:0, ab:0, inj:0, st:5'b00110, rdy:0, nstart:2};
    repeat (3) step;
    @(negedge clk);
    check("reset outputs", {strait_start, strait_test_mode, strait_bist_mode, busy, done, array_ready, status},
          12'b0);
    rst = 0;
    step;
    abort = 1; step; abort = 0;
    repeat (2) @(negedge clk);
    check("abort in idle", {busy, done, status}, 7'b0);
    clear_mon;
    pulse_go;
    wait_start("midreset");
    step; step;
    rst = 1; step; rst = 0;
    @(negedge clk);
    check("midreset idle", {busy, strait_test_mode, status}, 7'b0);
    repeat (3) @(negedge clk);
    check("midreset no done", dones, 0);
    foreach (tbl[i]) run_flow($sformatf("vec%0d", i), tbl[i]);
    for (int i = 0; i < 12; i++) begin
      r.mf = $urandom_range(0, 3) == 0;
      r.td = $urandom_range(0, 1) == 1;
      r.succ = $urandom_range(0, 2) != 0;
      r.early = $urandom_range(0, 1) == 1;
      r.ab = !r.mf && $urandom_range(0, 4) == 0;
      r.inj = $urandom_range(0, 1) == 1;
      r.st = model(r.mf, r.td, r.succ, r.ab);
      r.rdy = r.st == 5'b0;
      r.nstart = r.mf ? 1 : 2;
      run_flow($sformatf("rnd%0d", i), r);
    end
`ifdef STRAIT_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      clear_mon;
      pulse_go;
      wait_start("timeout");
      do begin @(negedge clk); n++; end while (!done && n < 40);
      check("timeout cycles", n, 17);
      check("timeout status", {array_ready, status}, {1'b0, 5'b01000});
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
